// File: rtl/mic_capture_pkg.sv
// mic_capture_pkg: shared state encoding, default widths and the sample magnitude helper
// Contents: DATA_W_DEF, mic_state_t (IDLE/ARMED/CAPTURE/DONE) and abs_val().
package mic_capture_pkg;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} mic_state_t;
    // One extra bit so that the most negative sample maps to its true magnitude.
    function automatic logic [DATA_W_DEF:0] abs_val(input logic [DATA_W_DEF-1:0] x);
        logic [DATA_W_DEF:0] e;
        e = {x[DATA_W_DEF-1], x};
        return e[DATA_W_DEF] ? -e : e;
    endfunction
endpackage

// File: rtl/mic_capture_ctrl_if.sv
// mic_capture_ctrl_if: SPRAM port plus host readout handshake
// master: the capture controller (drives ram_addr/ram_wdata/ram_we, rd_gnt/rd_data/rd_valid)
// slave:  the RAM and host side (drives ram_rdata, rd_req/rd_addr)
interface mic_capture_ctrl_if
    import mic_capture_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    modport master (
        output ram_addr, ram_wdata, ram_we, rd_gnt, rd_data, rd_valid,
        input  ram_rdata, rd_req, rd_addr
    );
    modport slave (
        input  ram_addr, ram_wdata, ram_we, rd_gnt, rd_data, rd_valid,
        output ram_rdata, rd_req, rd_addr
    );
endinterface

// File: rtl/mic_ram_arbiter.sv
// mic_ram_arbiter: one-entry pending write, write-first RAM port grant, read-valid pipe
// Ports: clk, rst (async, active-low), wr_req/wr_data (latch a sample), wr_addr (target of the
//   pending write), drop (discard the pending write), wr_fire (write issued this cycle), bus (master).
module mic_ram_arbiter
    import mic_capture_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              drop,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_fire,
    mic_capture_ctrl_if.master bus
);
    logic              pend_valid;
    logic [DATA_W-1:0] pend_data;
    assign wr_fire       = pend_valid & ~drop;
    assign bus.rd_gnt    = bus.rd_req & ~wr_fire;
    assign bus.ram_we    = wr_fire;
    assign bus.ram_wdata = wr_fire ? pend_data : '0;
    assign bus.ram_addr  = wr_fire ? wr_addr : bus.rd_gnt ? bus.rd_addr : '0;
    // The RAM returns data one cycle after the address, which lines up with rd_valid.
    assign bus.rd_data   = bus.rd_valid ? bus.ram_rdata : '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pend_valid   <= 1'b0;
            pend_data    <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            pend_valid   <= wr_req;
            if (wr_req) pend_data <= wr_data;
            bus.rd_valid <= bus.rd_gnt;
        end
endmodule

// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: sequences I2S sample capture into SPRAM and shares the port with host reads
// Ports: clk, rst (async, active-low), start/abort pulses, num_samples (0 = full depth),
//   s_data/s_flag from the I2S receiver, bus (RAM + host read, master), busy, done, wr_count.
// Build option: MIC_TRIGGER_EN adds the ARMED state and the |sample| >= TRIG_LEVEL trigger.
module mic_capture_ctrl
    import mic_capture_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = DATA_W_DEF
`ifdef MIC_TRIGGER_EN
    , parameter logic [DATA_W-1:0] TRIG_LEVEL = DATA_W'(2048)
`endif
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_samples,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_flag,
    mic_capture_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);
`ifdef MIC_TRIGGER_EN
    localparam mic_state_t START_ST = ARMED;
`else
    localparam mic_state_t START_ST = CAPTURE;
`endif
    mic_state_t      state;
    logic            s_flag_q;
    logic            ev;
    logic            accept;
    logic            wr_fire;
    logic [ADDR_W:0] target;
    assign ev = s_flag & ~s_flag_q;
`ifdef MIC_TRIGGER_EN
    // The triggering sample itself is accepted, so it lands at address 0.
    assign accept = ev & ~abort & ((state == CAPTURE) |
                    ((state == ARMED) & (abs_val(s_data) >= {1'b0, TRIG_LEVEL})));
`else
    assign accept = ev & ~abort & (state == CAPTURE);
`endif
    mic_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
        .clk(clk),
        .rst(rst),
        .wr_req(accept),
        .drop(abort),
        .wr_data(s_data),
        .wr_addr(wr_count[ADDR_W-1:0]),
        .wr_fire(wr_fire),
        .bus(bus)
    );
    // The write pointer is the low bits of wr_count; both restart at 0 on start.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            s_flag_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
            target   <= '0;
        end else begin
            s_flag_q <= s_flag;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start && (state == IDLE || state == DONE)) begin
                state    <= START_ST;
                busy     <= 1'b1;
                done     <= 1'b0;
                wr_count <= '0;
                target   <= {num_samples == '0, num_samples};
            end else begin
                if (wr_fire) wr_count <= wr_count + 1'b1;
                if (wr_fire && (wr_count + 1'b1) == target) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (state == ARMED && accept) begin
                    state <= CAPTURE;
                end
            end
        end
endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb_mic_capture_ctrl: randomized capture/readout bench against a sample-list reference model
module tb_mic_capture_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 16;
    typedef struct {int a; int d;} wr_t;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, s_flag = 1'b0;
    logic [AW-1:0] num_samples = '0;
    logic [DW-1:0] s_data = '0;
    logic busy, done;
    logic [AW:0] wr_count;
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    wr_t wlog[$], expq[$];
    int n_tests = 0, n_fail = 0;
    int exp_cnt = 0, exp_tgt = 0;
    bit cap = 0, armed = 0, dn = 0;
    mic_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mic_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
        .s_data(s_data), .s_flag(s_flag), .bus(bus.master), .busy(busy), .done(done),
        .wr_count(wr_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk)
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= ram[bus.ram_addr];
        end
    always @(negedge clk)
        if (rst && bus.ram_we) wlog.push_back('{int'(bus.ram_addr), int'(bus.ram_wdata)});
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic int mabs(logic [DW-1:0] d);
        int v;
        v = int'($signed(d));
        return v < 0 ? -v : v;
    endfunction
    function automatic void model_reset();
        cap = 0; armed = 0; dn = 0; exp_cnt = 0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    endfunction
    function automatic void model_event(logic [DW-1:0] d);
        if (armed && mabs(d) >= 2048) begin
            armed = 0;
            cap = 1;
        end
        if (cap) begin
            exp_mem[exp_cnt] = d;
            expq.push_back('{exp_cnt, int'(d)});
            exp_cnt++;
            if (exp_cnt == exp_tgt) begin
                cap = 0;
                dn = 1;
            end
        end
    endfunction
    task automatic pulse_start(int n);
        num_samples = AW'(n);
        start = 1;
        step();
        start = 0;
        num_samples = AW'($urandom);
        if (!cap && !armed) begin
`ifdef MIC_TRIGGER_EN
            armed = 1;
`else
            cap = 1;
`endif
            dn = 0;
            exp_cnt = 0;
            exp_tgt = (n == 0) ? DEPTH : n;
        end
    endtask
    task automatic pulse_abort();
        abort = 1;
        step();
        abort = 0;
        cap = 0; armed = 0; dn = 0;
    endtask
    task automatic send(logic [DW-1:0] d, int hold);
        s_data = d;
        s_flag = 1;
        step(hold);
        s_flag = 0;
        s_data = DW'($urandom);
        step(2 + $urandom_range(0, 3));
        model_event(d);
    endtask
    task automatic check_state(string t);
        check({t, "_busy"}, busy, cap || armed);
        check({t, "_done"}, done, dn);
        check({t, "_wr_count"}, wr_count, exp_cnt);
    endtask
    task automatic check_writes(string t);
        check({t, "_nwr"}, wlog.size(), expq.size());
        for (int i = 0; i < wlog.size() && i < expq.size(); i++) begin
            check({t, "_waddr"}, wlog[i].a, expq[i].a);
            check({t, "_wdata"}, wlog[i].d, expq[i].d);
        end
        wlog.delete();
        expq.delete();
    endtask
    task automatic read_chk(int a, string t);
        int w = 0;
        bus.rd_addr = AW'(a);
        bus.rd_req = 1;
        @(negedge clk);
        while (!bus.rd_gnt && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({t, "_gnt"}, bus.rd_gnt, 1);
        @(posedge clk);
        #1 bus.rd_req = 0;
        @(negedge clk);
        check({t, "_valid"}, bus.rd_valid, 1);
        check({t, "_data"}, bus.rd_data, exp_mem[a]);
        step();
    endtask
    task automatic collide(logic [DW-1:0] d, int a);
        s_data = d;
        s_flag = 1;
        step();
        bus.rd_addr = AW'(a);
        bus.rd_req = 1;
        model_event(d);
        @(negedge clk);
        check("col_gnt_blocked", bus.rd_gnt, 0);
        check("col_we", bus.ram_we, 1);
        @(negedge clk);
        check("col_gnt_next", bus.rd_gnt, 1);
        @(posedge clk);
        #1 bus.rd_req = 0;
        s_flag = 0;
        @(negedge clk);
        check("col_valid", bus.rd_valid, 1);
        check("col_data", bus.rd_data, exp_mem[a]);
        step(2);
    endtask
    initial begin
        bus.rd_req = 0;
        bus.rd_addr = '0;
        model_reset();
        step(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_gnt", bus.rd_gnt, 0);
        rst = 1;
        step();
        pulse_start(4);
        for (int i = 1; i <= 4; i++) send(DW'(i), 1);
        check_state("four");
        check_writes("four");
        send(16'h0005, 1);
        send(16'h0006, 1);
        check_state("after_done");
        check_writes("after_done");
        for (int i = 0; i < 4; i++) read_chk(i, "rd_four");
        pulse_start(8);
        send(16'h4000, 1);
        collide(16'h5000, 0);
        pulse_abort();
        check_state("abort2");
        send(16'h7777, 1);
        check_writes("abort2");
        pulse_start(3);
        check_state("restart");
        for (int i = 0; i < 3; i++) send(DW'(16'h6000 + i), 1);
        check_state("restart_done");
        check_writes("restart_done");
        pulse_start(5);
        send(16'h4444, 1);
        s_data = 16'h5555;
        s_flag = 1;
        step();
        abort = 1;
        @(negedge clk);
        check("abort_pend_we", bus.ram_we, 0);
        @(posedge clk);
        #1 abort = 0;
        s_flag = 0;
        cap = 0; armed = 0; dn = 0;
        step(2);
        check_state("abort_pend");
        check_writes("abort_pend");
        abort = 1;
        start = 1;
        num_samples = 3;
        step();
        abort = 0;
        start = 0;
        check_state("start_abort");
        pulse_start(0);
        send(16'h4001, 30);
        check_state("held_flag");
        check_writes("held_flag");
        for (int i = 1; i < 16; i++) send(DW'(16'h4100 + i), 1);
        check_state("full_depth");
        check_writes("full_depth");
        pulse_start(6);
        send(16'h4200, 1);
        send(16'h4201, 1);
        pulse_start(2);
        for (int i = 0; i < 4; i++) send(DW'(16'h4300 + i), 1);
        check_state("start_ignored");
        check_writes("start_ignored");
        pulse_start(8);
        send(16'h4400, 1);
        send(16'h4401, 1);
        check_writes("pre_reset");
        #2 rst = 0;
        #1;
        model_reset();
        check_state("async_rst");
        step();
        rst = 1;
        step();
`ifdef MIC_TRIGGER_EN
        pulse_start(4);
        send(16'd100, 1);
        send(16'hF801, 1);
        send(16'hF800, 1);
        check_state("trig");
        check_writes("trig");
        read_chk(0, "trig_rd");
        pulse_abort();
`endif
        for (int r = 0; r < 8; r++) begin
            int n;
            int k;
            n = $urandom_range(0, 15);
            pulse_start(n);
            k = $urandom_range(0, ((n == 0) ? 16 : n) + 2);
            for (int i = 0; i < k; i++) send(DW'($urandom), $urandom_range(1, 3));
            check_state("rnd");
            check_writes("rnd");
            for (int i = 0; i < 3; i++) read_chk($urandom_range(0, 15), "rnd_rd");
            if ($urandom_range(0, 1) == 1) begin
                pulse_abort();
                check_state("rnd_abort");
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
